// File: rtl/crc_pkg.sv
// Shared constants, types and helpers for the CRC stream engine.
// Optional feature macro: CRC_CRC16_EN (enables CRC-16 on crc_sel=2 and widens the remainder to 16 bits).
package crc_pkg;

    localparam logic [1:0] SEL_CRC5  = 2'd0;
    localparam logic [1:0] SEL_CRC8  = 2'd1;
    localparam logic [1:0] SEL_CRC16 = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;

    localparam logic [4:0]  POLY5  = 5'h05;
    localparam logic [7:0]  POLY8  = 8'h07;
    localparam logic [15:0] POLY16 = 16'h1021;

    localparam int CRC5_W  = $bits(POLY5);
    localparam int CRC8_W  = $bits(POLY8);
    localparam int CRC16_W = $bits(POLY16);

`ifdef CRC_CRC16_EN
    localparam int MAX_CRC_W = CRC16_W;
`else
    localparam int MAX_CRC_W = CRC8_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // True when this build can compute the selected polynomial.
    function automatic logic sel_supported(input logic [1:0] sel);
        logic ok;
        ok = (sel == SEL_CRC5) || (sel == SEL_CRC8);
`ifdef CRC_CRC16_EN
        ok = ok || (sel == SEL_CRC16);
`endif
        return ok;
    endfunction

    // CRC width for a supported select; 0 for anything unsupported.
    function automatic int crc_width(input logic [1:0] sel);
        int w;
        case (sel)
            SEL_CRC5:  w = CRC5_W;
            SEL_CRC8:  w = CRC8_W;
`ifdef CRC_CRC16_EN
            SEL_CRC16: w = CRC16_W;
`endif
            default:   w = 0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational multi-bit CRC step: consumes BITS_PER_CYC message bits (MSB first)
// into the running remainder for the selected polynomial.
// Optional feature macro: CRC_CRC16_EN (adds the CRC-16 polynomial).
module crc_step
    import crc_pkg::*;
#(
    parameter int BITS_PER_CYC = 4
) (
    input  logic [MAX_CRC_W-1:0]    rem_i,
    input  logic [BITS_PER_CYC-1:0] bits_i,
    input  logic [1:0]              sel_i,
    output logic [MAX_CRC_W-1:0]    rem_o
);

    localparam int IDX_W = $clog2(MAX_CRC_W);

    logic [MAX_CRC_W-1:0] poly;
    logic [MAX_CRC_W-1:0] mask;
    logic [IDX_W-1:0]     fbIdx;
    logic [MAX_CRC_W-1:0] remV;
    logic                 fb;

    // Polynomial, width mask and feedback tap for the selected CRC; narrower CRCs live in the low bits.
    always_comb begin
        poly  = '0;
        mask  = '1;
        fbIdx = '0;
        case (sel_i)
            SEL_CRC5: begin
                poly  = MAX_CRC_W'(POLY5);
                mask  = MAX_CRC_W'(5'h1F);
                fbIdx = IDX_W'(CRC5_W - 1);
            end
            SEL_CRC8: begin
                poly  = MAX_CRC_W'(POLY8);
                mask  = MAX_CRC_W'(8'hFF);
                fbIdx = IDX_W'(CRC8_W - 1);
            end
`ifdef CRC_CRC16_EN
            SEL_CRC16: begin
                poly  = MAX_CRC_W'(POLY16);
                mask  = MAX_CRC_W'(16'hFFFF);
                fbIdx = IDX_W'(CRC16_W - 1);
            end
`endif
            default: begin
                poly  = '0;
                mask  = '1;
                fbIdx = '0;
            end
        endcase
    end

    // Unrolled long division: shift each message bit in, subtract the polynomial when the top term falls out.
    always_comb begin
        remV = rem_i;
        fb   = 1'b0;
        for (int i = BITS_PER_CYC - 1; i >= 0; i--) begin
            fb   = remV[fbIdx];
            remV = ({remV[MAX_CRC_W-2:0], bits_i[i]} & mask) ^ (fb ? poly : '0);
        end
        rem_o = remV;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// CRC stream engine: one message per handshake, encode (append CRC) or check (verify codeword),
// result held until the consumer accepts it.
// Optional feature macro: CRC_CRC16_EN (crc_sel=2 selects CRC-16 0x1021).
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int MSG_W        = 60,
    parameter int BITS_PER_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       crc_sel,
    input  logic             mode,
    input  logic [MSG_W-1:0] message,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out,
    output logic             out_err
);

    localparam int N     = MSG_W / BITS_PER_CYC;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MAX_CRC_W-1:0] rem_q, rem_d;
    logic [MSG_W-1:0]     shift_q, shift_d;
    logic [1:0]           sel_q, sel_d;
    logic                 mode_q, mode_d;
    logic [MSG_W-1:0]     out_q, out_d;
    logic                 err_q, err_d;

    logic [MAX_CRC_W-1:0] remStep;
    logic [MSG_W-1:0]     shiftRot;
    logic [MSG_W-1:0]     lowMask;
    logic                 accept;

    crc_step #(
        .BITS_PER_CYC(BITS_PER_CYC)
    ) u_step (
        .rem_i (rem_q),
        .bits_i(shift_q[MSG_W-1 -: BITS_PER_CYC]),
        .sel_i (sel_q),
        .rem_o (remStep)
    );

    // The shift register rotates rather than shifts, so after N cycles it holds the padded message again.
    generate
        if (BITS_PER_CYC == MSG_W) begin : g_rot_full
            assign shiftRot = shift_q;
        end else begin : g_rot
            assign shiftRot = {shift_q[MSG_W-BITS_PER_CYC-1:0], shift_q[MSG_W-1 -: BITS_PER_CYC]};
        end
    endgenerate

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_err   = err_q;

    // Next-state logic: accept in IDLE or on the retiring DONE edge, divide in CALC, build the result on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        out_d   = out_q;
        err_d   = err_q;
        lowMask = (MSG_W'(1) << crc_width(crc_sel)) - MSG_W'(1);
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    sel_d   = crc_sel;
                    mode_d  = mode;
                    rem_d   = '0;
                    cnt_d   = '0;
                    shift_d = mode ? message : (message & ~lowMask);
                    if (sel_supported(crc_sel)) begin
                        state_d = CALC;
                        err_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        out_d   = '1;
                        err_d   = 1'b1;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d   = remStep;
                shift_d = shiftRot;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (mode_q) begin
                        out_d = (remStep == '0) ? '0 : '1;
                    end else begin
                        out_d = shiftRot | MSG_W'(remStep);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset discarding any in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed self-checking bench for crc_stream_engine with hand-computed expected codewords.
// Honours CRC_CRC16_EN the same way as the design.
module tb_crc_stream_engine;

    localparam int MSG_W = 60;
    localparam logic [MSG_W-1:0] ONES = 60'hFFF_FFFF_FFFF_FFFF;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       crc_sel;
    logic             mode;
    logic [MSG_W-1:0] message;
    logic             out_valid;
    logic             out_ready;
    logic [MSG_W-1:0] out;
    logic             out_err;

    int assertCount = 0;
    int failCount   = 0;

    crc_stream_engine #(
        .MSG_W       (MSG_W),
        .BITS_PER_CYC(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .crc_sel  (crc_sel),
        .mode     (mode),
        .message  (message),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request in IDLE; returns after the accepting edge with in_valid dropped.
    task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic md, input logic [MSG_W-1:0] msg);
        in_valid = 1'b1;
        crc_sel  = sel;
        mode     = md;
        message  = msg;
        #1;
        checkOutput({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        message  = '1;
        crc_sel  = ~sel;
        mode     = ~md;
    endtask

    // Count edges after acceptance until out_valid; an expired budget is a failure.
    task automatic waitResult(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Full transaction: request, result, latency and retire.
    task automatic runVector(input string tag, input logic [1:0] sel, input logic md, input logic [MSG_W-1:0] msg,
                             input logic [MSG_W-1:0] expOut, input logic expErr, input int expLat);
        int lat;
        applyStimulus(tag, sel, md, msg);
        waitResult(tag, lat);
        checkOutput({tag, "_out"}, 64'(out), 64'(expOut));
        checkOutput({tag, "_err"}, 64'(out_err), 64'(expErr));
        checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_retired"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [MSG_W-1:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        crc_sel   = 2'd0;
        mode      = 1'b0;
        message   = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out", 64'(out), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel_in_ready", 64'(in_ready), 64'd1);

        // Encode: remainder 0x07 for x^8 mod CRC-8, 0x05 for x^5 mod CRC-5; 15 edges to result.
        runVector("enc8", 2'd1, 1'b0, 60'h100, 60'h107, 1'b0, 15);
        runVector("enc5", 2'd0, 1'b0, 60'h20, 60'h25, 1'b0, 15);

        // Low pad bits are replaced in encode mode.
        runVector("enc8_pad", 2'd1, 1'b0, 60'h1AB, 60'h107, 1'b0, 15);

        // Check: valid codeword passes, single-bit error fails.
        runVector("chk8_ok", 2'd1, 1'b1, 60'h107, 60'h0, 1'b0, 15);
        runVector("chk8_bad", 2'd1, 1'b1, 60'h106, ONES, 1'b0, 15);

        // CRC-16 select, and the always-reserved select (DONE is entered on the accepting edge itself).
`ifdef CRC_CRC16_EN
        runVector("enc16", 2'd2, 1'b0, 60'h10000, 60'h11021, 1'b0, 15);
        runVector("enc16_zero", 2'd2, 1'b0, 60'h0, 60'h0, 1'b0, 15);
`else
        runVector("enc16", 2'd2, 1'b0, 60'h10000, ONES, 1'b1, 0);
        runVector("enc16_zero", 2'd2, 1'b0, 60'h0, ONES, 1'b1, 0);
`endif
        runVector("sel3", 2'd3, 1'b0, 60'h100, ONES, 1'b1, 0);

        // All-zero message.
        runVector("enc5_zero", 2'd0, 1'b0, 60'h0, 60'h0, 1'b0, 15);
        runVector("enc8_zero", 2'd1, 1'b0, 60'h0, 60'h0, 1'b0, 15);
        runVector("chk8_zero", 2'd1, 1'b1, 60'h0, 60'h0, 1'b0, 15);
        runVector("chk5_zero", 2'd0, 1'b1, 60'h0, 60'h0, 1'b0, 15);

        // Back-pressure: result held, new request ignored until retire, then accepted on the retiring edge.
        applyStimulus("bp", 2'd1, 1'b0, 60'h100);
        waitResult("bp", lat);
        held     = out;
        in_valid = 1'b1;
        crc_sel  = 2'd0;
        mode     = 1'b0;
        message  = 60'h20;
        seen     = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || out !== 60'h107 || in_ready) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("bp_held_out", 64'(held), 64'h107);
        checkOutput("bp_stall_bad_cycles", 64'(seen), 64'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_retire_rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        message   = '1;
        checkOutput("bp_new_accepted", 64'(out_valid), 64'd0);
        waitResult("bp2", lat);
        checkOutput("bp2_out", 64'(out), 64'h25);
        checkOutput("bp2_lat", 64'(lat), 64'd15);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset on CALC cycle 7: no partial result, outputs cleared, then a fresh request works.
        applyStimulus("mid", 2'd1, 1'b0, 60'h100);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rdy_in_rst", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_out", 64'(out), 64'd0);
        checkOutput("mid_out_err", 64'(out_err), 64'd0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("mid_no_partial", 64'(seen), 64'd0);
        runVector("post_rst", 2'd1, 1'b1, 60'h107, 60'h0, 1'b0, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
